// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its controller / function under test.
//   start      : begin a sweep (controller -> sequencer)
//   dut_out    : output of the function under test (blackbox -> sequencer)
//   in1..in3   : stimulus to the function under test, {in1,in2,in3} = vec_idx
//   vec_idx    : index of the vector currently driven
//   busy/done  : sweep in progress / sweep finished (sticky)
//   pass       : no mismatches, valid while done
//   err_count  : number of mismatching vectors (0..8)
//   err_mask   : bit i set if vector i mismatched
interface truth_table_sequencer_if;
    logic       start;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic [2:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] err_mask;

    // Controller / environment side: issues start, supplies the blackbox output.
    modport master (
        output start,
        output dut_out,
        input  in1,
        input  in2,
        input  in3,
        input  vec_idx,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  err_mask
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  dut_out,
        output in1,
        output in2,
        output in3,
        output vec_idx,
        output busy,
        output done,
        output pass,
        output err_count,
        output err_mask
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive hardware checker for a 3-input combinational function.
// Steps {in1,in2,in3} through all eight vectors, holds each for SETTLE_CYCLES+1
// cycles, samples dut_out and compares it with EXPECTED[vec_idx], accumulating
// a mismatch mask and count.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : truth_table_sequencer_if.slave (start, dut_out in; stimulus and results out)
module truth_table_sequencer #(
    parameter logic [7:0]  EXPECTED      = 8'b0001_0100,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    truth_table_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned VEC_W       = 3;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(7);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [VEC_W-1:0] vec_q,     vec_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       err_msk_q, err_msk_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            err_msk_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            err_msk_q <= err_msk_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        err_msk_d = err_msk_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    vec_d     = '0;
                    cnt_d     = '0;
                    err_cnt_d = '0;
                    err_msk_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                // Mismatch bookkeeping uses the pre-increment index.
                if (bus.dut_out != EXPECTED[vec_q]) begin
                    err_msk_d[vec_q] = 1'b1;
                    err_cnt_d        = err_cnt_q + 4'd1;
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are direct decodes of registered state.
    assign bus.vec_idx   = vec_q;
    assign bus.in1       = vec_q[2];
    assign bus.in2       = vec_q[1];
    assign bus.in3       = vec_q[0];
    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err_count = err_cnt_q;
    assign bus.err_mask  = err_msk_q;
    // Gated with done so pass reads 0 out of reset and mid-sweep.
    assign bus.pass      = (state_q == ST_DONE) && (err_cnt_q == 4'd0);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed self-checking bench for truth_table_sequencer (EXPECTED=8'b0001_0100, S=2).
module tb_truth_table_sequencer;

    localparam logic [7:0] EXP_TABLE = 8'b0001_0100;

    logic clk;
    logic rst;
    logic [7:0] model_table;
    int n_checks;
    int n_fail;

    truth_table_sequencer_if bus ();

    truth_table_sequencer #(
        .EXPECTED      (EXP_TABLE),
        .SETTLE_CYCLES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural blackbox: combinational lookup on the driven vector.
    assign bus.dut_out = model_table[{bus.in1, bus.in2, bus.in3}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start pulse sampled at the next rising edge (E0); returns #1 after E0.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Runs one sweep from start. Reports the edge at which done was first seen
    // (-1 if not within 40 edges) and whether vec_idx/busy/stimulus followed the
    // expected schedule. If glitch_at >= 0, start is pulsed after that edge.
    task automatic run_sweep(input int glitch_at, output int done_edge, output bit steps_ok);
        int exp_vec;
        done_edge = -1;
        steps_ok  = 1'b1;
        pulse_start();
        if (bus.vec_idx !== 3'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) steps_ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n - 1 == glitch_at) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            exp_vec = (n / 3 > 7) ? 7 : n / 3;
            if (bus.vec_idx !== 3'(exp_vec)) steps_ok = 1'b0;
            if ({bus.in1, bus.in2, bus.in3} !== bus.vec_idx) steps_ok = 1'b0;
            if (bus.done === 1'b1) begin
                if (bus.busy !== 1'b0) steps_ok = 1'b0;
                done_edge = n;
                break;
            end
            if (bus.busy !== 1'b1) steps_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in1, bus.in2, bus.in3, bus.vec_idx, bus.busy, bus.done, bus.pass} !== 9'b0 ||
            bus.err_count !== 4'd0 || bus.err_mask !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: vec=%0d busy=%b done=%b pass=%b cnt=%0d mask=%h, required all zero",
                     bus.vec_idx, bus.busy, bus.done, bus.pass, bus.err_count, bus.err_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_all_pass();
        int de;
        bit ok;
        model_table = EXP_TABLE;
        run_sweep(-1, de, ok);
        n_checks++;
        if (de !== 24) begin
            n_fail++;
            $display("FAIL pass_done_edge: done at E%0d, required E24", de);
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_vec_schedule: schedule ok=%b, required 1", ok);
        end
        n_checks++;
        if (bus.err_count !== 4'd0 || bus.err_mask !== 8'h00 || bus.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_results: cnt=%0d mask=%h pass=%b, required 0 00 1",
                     bus.err_count, bus.err_mask, bus.pass);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.vec_idx !== 3'd7) begin
            n_fail++;
            $display("FAIL done_sticky: done=%b pass=%b vec=%0d, required 1 1 7",
                     bus.done, bus.pass, bus.vec_idx);
        end
    endtask

    task automatic test_all_fail();
        int de;
        bit ok;
        model_table = ~EXP_TABLE;
        run_sweep(-1, de, ok);
        n_checks++;
        if (de !== 24 || bus.err_count !== 4'd8 || bus.err_mask !== 8'hFF || bus.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL all_fail: done E%0d cnt=%0d mask=%h pass=%b, required E24 8 ff 0",
                     de, bus.err_count, bus.err_mask, bus.pass);
        end
    endtask

    task automatic test_single_fail();
        int de;
        bit ok;
        model_table = EXP_TABLE | 8'h20;
        run_sweep(-1, de, ok);
        n_checks++;
        if (de !== 24 || bus.err_count !== 4'd1 || bus.err_mask !== 8'h20 || bus.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL vec5_fail: done E%0d cnt=%0d mask=%h pass=%b, required E24 1 20 0",
                     de, bus.err_count, bus.err_mask, bus.pass);
        end
    endtask

    task automatic test_start_ignored();
        int de;
        bit ok;
        model_table = EXP_TABLE ^ 8'h09;
        run_sweep(9, de, ok);
        n_checks++;
        if (de !== 24 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy_timing: done E%0d ok=%b, required E24 1", de, ok);
        end
        n_checks++;
        if (bus.err_count !== 4'd2 || bus.err_mask !== 8'h09) begin
            n_fail++;
            $display("FAIL start_while_busy_results: cnt=%0d mask=%h, required 2 09",
                     bus.err_count, bus.err_mask);
        end
    endtask

    task automatic test_reset_mid_sweep();
        model_table = ~EXP_TABLE;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (bus.vec_idx !== 3'd3 || bus.err_mask !== 8'h07 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: vec=%0d mask=%h busy=%b, required 3 07 1",
                     bus.vec_idx, bus.err_mask, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.vec_idx !== 3'd0 || {bus.in1, bus.in2, bus.in3} !== 3'b000 ||
            bus.err_mask !== 8'h00 || bus.err_count !== 4'd0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b vec=%0d in=%b%b%b mask=%h cnt=%0d done=%b, required all zero",
                     bus.busy, bus.vec_idx, bus.in1, bus.in2, bus.in3, bus.err_mask, bus.err_count, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_hold_after_reset: busy=%b done=%b vec=%0d, required 0 0 0",
                     bus.busy, bus.done, bus.vec_idx);
        end
    endtask

    task automatic test_restart_from_done();
        int de;
        bit ok;
        model_table = EXP_TABLE | 8'h20;
        run_sweep(-1, de, ok);
        n_checks++;
        if (bus.done !== 1'b1 || bus.err_count !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_precondition: done=%b cnt=%0d, required 1 1", bus.done, bus.err_count);
        end
        model_table = EXP_TABLE;
        pulse_start();
        n_checks++;
        if (bus.done !== 1'b0 || bus.err_count !== 4'd0 || bus.err_mask !== 8'h00 ||
            bus.busy !== 1'b1 || bus.vec_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_clear: done=%b cnt=%0d mask=%h busy=%b vec=%0d, required 0 0 00 1 0",
                     bus.done, bus.err_count, bus.err_mask, bus.busy, bus.vec_idx);
        end
        de = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                de = n;
                break;
            end
        end
        n_checks++;
        if (de !== 24 || bus.pass !== 1'b1 || bus.err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_second_sweep: done E%0d pass=%b cnt=%0d, required E24 1 0",
                     de, bus.pass, bus.err_count);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_table = EXP_TABLE;
        bus.start   = 1'b0;
        rst         = 1'b1;
        test_reset();
        test_all_pass();
        test_all_fail();
        test_single_fail();
        test_start_ignored();
        test_reset_mid_sweep();
        test_restart_from_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Synthesizable stimulus-and-check stage that sits directly upstream of the 3-input `blackbox` function under test. It drives `{in1,in2,in3}` through all eight combinations, lets each settle, samples the blackbox `out`, and compares it against a parameterized expected truth table. It accumulates a per-vector mismatch mask and an error count, then reports pass/fail, so the exhaustive check runs in hardware instead of only in the simulation bench.

## Interface
- `EXPECTED`, 8'b0001_0100: expected output per vector; bit i is f(i), where i = {in1,in2,in3}.
- `SETTLE_CYCLES`, 2: cycles a vector is held before sampling; legal range 1..15.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `dut_out`  in  1  blackbox `out`.
- `in1`, `in2`, `in3`  out  1 each  registered stimulus, equal to {in1,in2,in3} = vec_idx.
- `vec_idx`  out  3  index of the vector currently driven.
- `busy`  out  1  high in SETTLE or CHECK.
- `done`  out  1  high in DONE; sticky until the next start or reset.
- `pass`  out  1  valid while `done`; equals (err_count == 0).
- `err_count`  out  4  number of mismatching vectors, 0..8.
- `err_mask`  out  8  bit i set if vector i mismatched.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: `busy=0`, `done=0`, and the inputs hold their last value.
  - `start=1` clears `vec_idx`, `err_count`, `err_mask` and the settle counter, then moves to SETTLE.
- SETTLE: the settle counter increments each cycle.
  - After `SETTLE_CYCLES` cycles in SETTLE, move to CHECK.
  - The counter clears on leaving SETTLE.
- CHECK: lasts exactly one cycle. At its closing edge, `dut_out` is compared with `EXPECTED[vec_idx]`.
  - On mismatch: set `err_mask[vec_idx]` and increment `err_count`.
  - If `vec_idx == 7`, go to DONE. Otherwise increment `vec_idx` (which updates `in1..in3` on the same edge) and return to SETTLE.
- DONE: `done=1`, and `pass`, `err_count`, `err_mask` hold their values.
  - `start=1` restarts exactly as from IDLE: results clear and `done` drops on the next edge.
- Rules:
  - `start` is ignored while `busy`.
  - `vec_idx` never wraps inside a sweep; the 7→0 transition happens only via start.
  - `err_count` cannot exceed 8, so it needs no saturation.
  - The mismatch update and the index increment happen on the same edge and do not interfere: the update uses the pre-increment index.
  - `dut_out` is assumed combinational from `in1..in3`. The sequencer adds no synchronizer.

## Timing
- Reset values: state IDLE; `in1=in2=in3=0`, `vec_idx=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `err_mask=8'h00`.
- Reset mid-sweep returns all outputs to these values immediately (asynchronously) and abandons the sweep. No partial results are retained.
- Edge numbering: the edge sampling `start` is E0.
  - After E0, vector 0 is driven and `busy=1`.
  - Vector k is sampled at edge E((k+1)(S+1)), where S = `SETTLE_CYCLES`.
  - `done` rises after E(8(S+1)); with S=2, that is after E24.
  - `busy` falls in the same cycle that `done` rises.
- Each vector is stable on `in1..in3` for S+1 full cycles before its sample edge.
- `pass` is combinational from `err_count` but is only meaningful while `done=1`.

## Test plan
- DUT model f = EXPECTED (default 8'b0001_0100), S=2, pulse start → `done` rises after E24; `err_count=0`, `err_mask=8'h00`, `pass=1`; `vec_idx` steps 0..7, each value held 3 cycles.
- DUT model = ~EXPECTED → `err_count=8`, `err_mask=8'hFF`, `pass=0`.
- DUT model differing only at vector 5 (returns 1 for input 101) → `err_count=1`, `err_mask=8'h20`, `pass=0`.
- Pulse start again at vector 3 while busy → ignored; the sweep completes at the original E24 with unchanged results.
- Assert rst while `vec_idx=3` in SETTLE → in the same cycle, `busy=0`, `vec_idx=0`, `in1..in3=000`, `err_mask=0`. The FSM stays in IDLE until a new start.
- From DONE with `err_count=1`, pulse start → next cycle `done=0`, `err_count=0`, `err_mask=0`, `busy=1`. A second sweep with the correct DUT ends with `pass=1`.
